instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
Assembles RV32I field bundles (operation class, funct3, alt bit, register numbers, immediate) into 32-bit instruction words; it is the inverse of the decode stage.
- Output words are paired with a sequential instruction-memory address, for program loading and for self-test stimulus generation.
- Single registered stage with valid/ready on both sides, a running address counter and a sticky error flag.

Parameters:
BASE_ADDR, 32'h0000_0000, address loaded into the address counter at reset
CNT_W, 16, width of the emitted-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept bundle
op_class  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BR, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP; 9-15 illegal
funct3  in  3  funct3 field
alt  in  1  selects funct7=0100000 (sub/sra/srai)
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
imm  in  32  immediate, byte-offset value as in the ISA (sign-extended)
addr_load  in  1  load addr_value into address counter
addr_value  in  32  new address counter value
out_valid  out  1  instr_word/instr_addr valid
out_ready  in  1  sink accepts word
instr_word  out  32  encoded instruction
instr_addr  out  32  address for instr_word
err  out  1  sticky: an illegal bundle was encoded
count  out  CNT_W  instructions accepted by the sink, saturating

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, instr_word=0, instr_addr=BASE_ADDR, err=0, count=0. Any held word is dropped.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
  - An input transfer (in_valid && in_ready) registers the encoded word next cycle with out_valid=1. Latency is 1 cycle.
  - out_valid, instr_word and instr_addr hold stable while out_valid && !out_ready.
  - Output-only transfer: out_valid drops to 0.
- Address counter:
  - addr_ctr starts at BASE_ADDR.
  - On an input transfer: instr_addr <= addr_ctr, then addr_ctr += 4, wrapping modulo 2^32.
  - addr_load sets addr_ctr=addr_value. If an input transfer occurs in the same cycle, that word takes addr_value and addr_ctr becomes addr_value+4.
- count increments on each output transfer and saturates at all-ones.
- Field placement: opcode [6:0]; rd [11:7]; funct3 [14:12]; rs1 [19:15]; rs2 [24:20].
- Per-class opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BR 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011.
- Immediate packing:
  - I-type (JALR, LOAD, OPIMM): imm[11:0] -> [31:20].
  - OPIMM shift (funct3 001/101): [24:20]=imm[4:0], [31:25]=alt?0100000:0000000.
  - S-type: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
  - B-type: imm[12] -> 31, imm[10:5] -> [30:25], imm[4:1] -> [11:8], imm[11] -> 7.
  - U-type: imm[31:12] -> [31:12].
  - J-type: imm[20] -> 31, imm[10:1] -> [30:21], imm[11] -> 20, imm[19:12] -> [19:12].
  - OP: [31:25]=alt?0100000:0.
- Unused fields are forced to 0: rd for S/B; rs1/rs2 where the format lacks them; funct3 for LUI/AUIPC/JAL; funct3=000 for JALR.
- Illegal bundles encode as NOP 32'h0000_0013 and set err on the registering edge. Illegal means any of:
  - op_class >= 9;
  - BR with funct3 010/011;
  - LOAD with funct3 011/110/111;
  - STORE with funct3 > 010;
  - alt=1 except OP funct3 000/101 or OPIMM funct3 101.
- err clears only on rst.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: the bundle is illegal (NOP + err) in any of these cases:
  - imm is not representable by the format's sign-extended range: I/S ±2^11, B ±2^12, J ±2^20;
  - B/J imm[0]=1;
  - U imm[11:0]!=0;
  - shift imm[31:5]!=0.
- Undefined: the excess bits are silently truncated.

Test Plan:
- OPIMM f3=000, rd=1, rs1=0, imm=5 -> instr_word 0x00500093, instr_addr 0x0, out_valid 1 cycle after accept.
- OP f3=000, alt=1, rd=3, rs1=1, rs2=2 -> 0x402081B3; STORE f3=010, rs1=2, rs2=5, imm=-4 -> 0xFE512E23.
- BR f3=000, rs1=1, rs2=2, imm=8 -> 0x00208463; JAL rd=1, imm=2048 -> 0x001000EF.
- Four back-to-back bundles with out_ready=1 and 2 cycles of out_ready=0 mid-stream:
  - instr_addr sequence is 0,4,8,C;
  - output is held stable while stalled;
  - count=4 at the end.
- addr_load=1, addr_value=0xFFFF_FFFC concurrent with an accept, then a second accept -> addrs 0xFFFF_FFFC, 0x0000_0000 (wrap).
- op_class=12 -> word 0x00000013, err=1 sticky through later legal bundles; rst with out_valid=1 held -> out_valid=0, err=0, count=0 next cycle.
- With IMM_RANGE_CHECK_EN, OPIMM imm=4096 -> NOP + err; without, the same bundle gives 0x00000093.

Source files
------------

// File: rtl/instruction_encoder.sv
// RV32I field-bundle to instruction-word encoder: one registered stage with valid/ready,
// a running instruction-memory address and a sticky illegal-bundle flag.
// Optional macro IMM_RANGE_CHECK_EN: out-of-range immediates are rejected instead of truncated.
module instruction_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_class,
  input  logic [2:0]       funct3,
  input  logic             alt,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  input  logic             addr_load,
  input  logic [31:0]      addr_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_word,
  output logic [31:0]      instr_addr,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam logic [3:0] C_LUI   = 4'd0;
  localparam logic [3:0] C_AUIPC = 4'd1;
  localparam logic [3:0] C_JAL   = 4'd2;
  localparam logic [3:0] C_JALR  = 4'd3;
  localparam logic [3:0] C_BR    = 4'd4;
  localparam logic [3:0] C_LOAD  = 4'd5;
  localparam logic [3:0] C_STORE = 4'd6;
  localparam logic [3:0] C_OPIMM = 4'd7;
  localparam logic [3:0] C_OP    = 4'd8;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Handshake: a side transfers on the rising clk edge where its valid and ready are both 1.
  // in_ready only depends on out_valid/out_ready, so a full pipe still accepts when drained.
  logic        in_xfer, out_xfer;
  logic [31:0] enc_word;
  logic        illegal;
  logic        is_shift;
  logic [6:0]  funct7;
  logic [31:0] addr_ctr;
  logic [31:0] addr_base;

  assign in_ready  = !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign addr_base = addr_load ? addr_value : addr_ctr;

`ifdef IMM_RANGE_CHECK_EN
  logic fits_12, fits_13, fits_21;
  assign fits_12 = (imm[31:11] == {21{imm[11]}});
  assign fits_13 = (imm[31:12] == {20{imm[12]}});
  assign fits_21 = (imm[31:20] == {12{imm[20]}});
`endif

  always_comb begin
    enc_word = '0;
    illegal  = 1'b0;
    is_shift = (op_class == C_OPIMM) && (funct3 == 3'b001 || funct3 == 3'b101);
    funct7   = alt ? 7'b0100000 : 7'b0000000;
    case (op_class)
      C_LUI:   enc_word = {imm[31:12], rd, 7'b0110111};
      C_AUIPC: enc_word = {imm[31:12], rd, 7'b0010111};
      C_JAL:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      C_JALR:  enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      C_BR: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
      end
      C_LOAD: begin
        enc_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
      end
      C_STORE: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
        if (funct3 > 3'b010) illegal = 1'b1;
      end
      C_OPIMM: begin
        if (is_shift) enc_word = {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011};
        else          enc_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      end
      C_OP:    enc_word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      default: illegal = 1'b1;
    endcase
    // alt is only meaningful for sub/sra (OP) and srai (OPIMM)
    if (alt && !((op_class == C_OP && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                 (op_class == C_OPIMM && funct3 == 3'b101)))
      illegal = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
    case (op_class)
      C_LUI, C_AUIPC: if (imm[11:0] != 12'd0) illegal = 1'b1;
      C_JAL:          if (!fits_21 || imm[0]) illegal = 1'b1;
      C_BR:           if (!fits_13 || imm[0]) illegal = 1'b1;
      C_JALR, C_LOAD, C_STORE: if (!fits_12) illegal = 1'b1;
      C_OPIMM: begin
        if (is_shift) begin
          if (imm[31:5] != 27'd0) illegal = 1'b1;
        end else if (!fits_12) begin
          illegal = 1'b1;
        end
      end
      default: ;
    endcase
`endif
    if (illegal) enc_word = NOP_WORD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      instr_word <= '0;
      instr_addr <= BASE_ADDR;
      addr_ctr   <= BASE_ADDR;
      err        <= 1'b0;
      count      <= '0;
    end else begin
      if (in_xfer) begin
        out_valid  <= 1'b1;
        instr_word <= enc_word;
        instr_addr <= addr_base;
        addr_ctr   <= addr_base + 32'd4;
        if (illegal) err <= 1'b1;
      end else begin
        if (out_xfer)  out_valid <= 1'b0;
        if (addr_load) addr_ctr  <= addr_value;
      end
      if (out_xfer && count != '1) count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed vectors plus randomized bundles, checked by a
// queue-based scoreboard fed from an arithmetic reference model of the RV32I formats.
module tb_instruction_encoder;
  localparam int          CNT_W = 3;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic             clk, rst;
  logic             in_valid, in_ready;
  logic [3:0]       op_class;
  logic [2:0]       funct3;
  logic             alt;
  logic [4:0]       rd, rs1, rs2;
  logic [31:0]      imm;
  logic             addr_load;
  logic [31:0]      addr_value;
  logic             out_valid, out_ready;
  logic [31:0]      instr_word, instr_addr;
  logic             err;
  logic [CNT_W-1:0] count;

  instruction_encoder #(.BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .funct3(funct3), .alt(alt), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .addr_load(addr_load), .addr_value(addr_value),
    .out_valid(out_valid), .out_ready(out_ready), .instr_word(instr_word),
    .instr_addr(instr_addr), .err(err), .count(count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [64:0] exp_q[$];   // {err, addr, word}
  logic [31:0] m_ctr;
  bit          m_err;
  int          m_cnt;
  bit          ready_rand;
  bit          prev_stall;
  logic [63:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: builds the word from the ISA field positions with shifts and masks.
  function automatic void model_enc(input logic [31:0] op, f3, input bit a,
                                    input logic [31:0] rdv, r1, r2, iv,
                                    output logic [31:0] w, output bit bad);
    logic [31:0] opc [0:8];
    logic [31:0] f7;
    bit          shift;
`ifdef IMM_RANGE_CHECK_EN
    longint      s;
    s = longint'($signed(iv));
`endif
    opc = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h03, 32'h23, 32'h13, 32'h33};
    shift = (op == 7) && (f3 == 1 || f3 == 5);
    f7 = a ? 32'h20 : 32'h0;
    bad = (op > 8) || (op == 4 && (f3 == 2 || f3 == 3)) || (op == 5 && f3 inside {3, 6, 7}) ||
          (op == 6 && f3 > 2) || (a && !((op == 8 && (f3 == 0 || f3 == 5)) || (op == 7 && f3 == 5)));
`ifdef IMM_RANGE_CHECK_EN
    if ((op inside {3, 5, 6} || (op == 7 && !shift)) && (s < -2048 || s > 2047)) bad = 1;
    if (op == 4 && (s < -4096 || s > 4095 || (iv & 1) != 0)) bad = 1;
    if (op == 2 && (s < -(64'sd1 << 20) || s >= (64'sd1 << 20) || (iv & 1) != 0)) bad = 1;
    if (op <= 1 && (iv % 4096) != 0) bad = 1;
    if (shift && iv > 31) bad = 1;
`endif
    w = 32'h13;
    if (bad) return;
    case (op)
      0, 1: w = (iv & 32'hFFFF_F000) | rdv << 7 | opc[op];
      2: w = ((iv >> 20) & 1) << 31 | ((iv >> 1) & 32'h3FF) << 21 | ((iv >> 11) & 1) << 20 |
             ((iv >> 12) & 32'hFF) << 12 | rdv << 7 | opc[op];
      3: w = (iv & 32'hFFF) << 20 | r1 << 15 | rdv << 7 | opc[op];
      4: w = ((iv >> 12) & 1) << 31 | ((iv >> 5) & 32'h3F) << 25 | r2 << 20 | r1 << 15 |
             f3 << 12 | ((iv >> 1) & 32'hF) << 8 | ((iv >> 11) & 1) << 7 | opc[op];
      5: w = (iv & 32'hFFF) << 20 | r1 << 15 | f3 << 12 | rdv << 7 | opc[op];
      6: w = ((iv >> 5) & 32'h7F) << 25 | r2 << 20 | r1 << 15 | f3 << 12 | (iv & 32'h1F) << 7 | opc[op];
      7: if (shift) w = f7 << 25 | (iv & 32'h1F) << 20 | r1 << 15 | f3 << 12 | rdv << 7 | opc[op];
         else       w = (iv & 32'hFFF) << 20 | r1 << 15 | f3 << 12 | rdv << 7 | opc[op];
      default: w = f7 << 25 | r2 << 20 | r1 << 15 | f3 << 12 | rdv << 7 | opc[op];
    endcase
  endfunction

  // driver tasks: all drives happen 1ns after posedge
  task automatic send(input int op, f3, input bit a, input int rdv, r1, r2, input logic [31:0] iv,
                      input bit ld = 0, input logic [31:0] ldv = 0,
                      input bit use_exp = 0, input logic [31:0] exp_w = 0);
    logic [31:0] w, addr;
    bit          bad, acc;
    model_enc(op, f3, a, rdv, r1, r2, iv, w, bad);
    if (use_exp) w = exp_w;
    op_class = 4'(op); funct3 = 3'(f3); alt = a; rd = 5'(rdv); rs1 = 5'(r1); rs2 = 5'(r2);
    imm = iv; addr_load = ld; addr_value = ldv; in_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready never 1 for op_class %0d", op);
    end else begin
      addr  = ld ? ldv : m_ctr;
      m_ctr = addr + 32'd4;
      m_err = m_err | bad;
      exp_q.push_back({m_err, addr, w});
    end
    in_valid = 1'b0; addr_load = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete(); m_ctr = BASE; m_err = 0; m_cnt = 0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_instr_word", 64'(instr_word), 64'd0);
    check("rst_instr_addr", 64'(instr_addr), 64'(BASE));
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 300) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 300) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
    end
  endtask

  // scoreboard monitor: pops on every output transfer and checks stall stability
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", {instr_addr, instr_word}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word: got %h at %h expected none", instr_word, instr_addr);
        end else begin
          e = exp_q.pop_front();
          check("instr_word", 64'(instr_word), 64'(e[31:0]));
          check("instr_addr", 64'(instr_addr), 64'(e[63:32]));
          check("err", 64'(err), 64'(e[64]));
          m_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {instr_addr, instr_word};
    end
  end

  always @(posedge clk) begin
    if (ready_rand) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, f3, sel;
    bit a;
    logic [31:0] iv;
    rst = 1'b1; in_valid = 0; op_class = 0; funct3 = 0; alt = 0; rd = 0; rs1 = 0; rs2 = 0;
    imm = 0; addr_load = 0; addr_value = 0; out_ready = 1'b0; ready_rand = 0;
    m_ctr = BASE; m_err = 0; m_cnt = 0;
    do_reset();

    // first word, held so the one-cycle latency is visible
    send(7, 0, 0, 1, 0, 0, 5, 0, 0, 1, 32'h0050_0093);
    @(negedge clk);
    check("latency_valid", 64'(out_valid), 64'd1);
    check("latency_addr", 64'(instr_addr), 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    send(8, 0, 1, 3, 1, 2, 0, 0, 0, 1, 32'h4020_81B3);
    send(6, 2, 0, 0, 2, 5, 32'hFFFF_FFFC, 0, 0, 1, 32'hFE51_2E23);
    send(4, 0, 0, 0, 1, 2, 8, 0, 0, 1, 32'h0020_8463);
    send(2, 0, 0, 1, 0, 0, 2048, 0, 0, 1, 32'h0010_00EF);
    drain();

    // four back-to-back with a two-cycle sink stall
    do_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) send(7, 0, 0, i + 1, i, 0, 32'(i * 3));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("count_after_4", 64'(count), 64'd4);

    // address load concurrent with accept, then wrap
    send(8, 0, 0, 5, 6, 7, 0, 1, 32'hFFFF_FFFC);
    send(8, 7, 0, 8, 9, 10, 0);
    drain();

    // illegal bundle, then err must stay set through legal ones
    send(12, 0, 0, 1, 2, 3, 32'h7FF, 0, 0, 1, 32'h0000_0013);
    send(5, 2, 0, 4, 5, 0, 16);
    send(3, 0, 0, 1, 2, 0, 32'hFFFF_F800);
    drain();

    // reset while a word is held
    out_ready = 1'b0;
    send(0, 0, 0, 3, 0, 0, 32'h1234_5000);
    @(negedge clk);
    check("held_before_rst", 64'(out_valid), 64'd1);
    do_reset();
    out_ready = 1'b1;

`ifdef IMM_RANGE_CHECK_EN
    send(7, 0, 0, 1, 0, 0, 4096, 0, 0, 1, 32'h0000_0013);
`else
    send(7, 0, 0, 1, 0, 0, 4096, 0, 0, 1, 32'h0000_0093);
`endif
    drain();

    // randomized stimulus with random sink back-pressure
    ready_rand = 1;
    for (int n = 0; n < 300; n++) begin
      op  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      f3  = $urandom_range(0, 7);
      a   = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0: iv = 32'($urandom_range(0, 64)) - 32'd32;
        1: iv = $urandom;
        2: iv = 32'($urandom_range(0, 8192)) - 32'd4096;
        default: iv = 32'($urandom_range(0, 1 << 21)) - 32'(1 << 20);
      endcase
      if ($urandom_range(0, 1) == 0) iv = iv & 32'hFFFF_FFFE;
      send(op, f3, a, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), iv,
           ($urandom_range(0, 15) == 0), $urandom & 32'hFFFF_FFFC);
    end
    ready_rand = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    check("count_saturated", 64'(count), 64'(m_cnt > 7 ? 7 : m_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
